// File: rtl/my_divider.sv
// 32-bit unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero completes in one cycle with Q = all ones and R = dividend.
module my_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Q,
    output logic [31:0] R,
    output logic        dz
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic [31:0] q_q, q_d;
    logic [31:0] r_q, r_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic [32:0] step_rem;
    logic [31:0] step_quo;

    // Sign of the trial difference is the restore decision: negative means s < div.
    always_comb begin
        shifted  = {rem_q[31:0], quo_q[31]};
        trial    = shifted - {1'b0, div_q};
        step_rem = trial[32] ? shifted : trial;
        step_quo = {quo_q[30:0], ~trial[32]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (B == 32'd0) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                        q_d    = 32'hFFFF_FFFF;
                        r_d    = A;
                    end else begin
                        rem_d   = 33'd0;
                        quo_d   = A;
                        div_d   = B;
                        cnt_d   = 6'd0;
                        dz_d    = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    q_d     = step_quo;
                    r_d     = step_rem[31:0];
                    done_d  = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            rem_q   <= 33'd0;
            quo_q   <= 32'd0;
            div_q   <= 32'd0;
            q_q     <= 32'd0;
            r_q     <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_my_divider.sv
// Bench for my_divider: directed vector table, hand-written corner sequences,
// and a back-to-back random regression checked against plain / and % arithmetic.
module tb_my_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [31:0] R;
    logic        dz;

    int n_checks = 0;
    int n_pass   = 0;

    // Handshake: start is sampled at a rising edge only while busy=0; done is a
    // one-cycle pulse and Q/R/dz are valid from that cycle. Inputs change on the
    // falling edge and outputs are sampled on the falling edge.
    my_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    // Issue one request, wait for done, report result, latency and busy cycles.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] gq, output logic [31:0] gr,
                          output logic gz, output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
            if (busy) busy_cnt++;
        end while (!done && lat < 60);
        gq = Q;
        gr = R;
        gz = dz;
    endtask

    initial begin
        logic [31:0] gq, gr;
        logic        gz;
        int          lat, bc, cyc;
        logic        seen_done;
        logic [63:0] e;
        logic [31:0] ra, rb;
        logic [31:0] qa [$];
        logic [31:0] qb [$];

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,      1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,      1'b0};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,      1'b0};
        vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3,      1'b0};
        vecs[4] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,      1'b1};
        vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,      1'b0};
        vecs[6] = '{32'd7,          32'd7,          32'd1,          32'd0,      1'b0};
        vecs[7] = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,      1'b0};
        vecs[8] = '{32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF, 1'b0};
        vecs[9] = '{32'd1000,       32'd3,          32'd333,        32'd1,      1'b0};

        // Reset state
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz",   64'(dz),   64'd0);
        check("reset_q",    64'(Q),    64'd0);
        check("reset_r",    64'(R),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            do_div(vecs[i].a, vecs[i].b, gq, gr, gz, lat, bc);
            check($sformatf("vec%0d_q", i),   64'(gq), 64'(vecs[i].q));
            check($sformatf("vec%0d_r", i),   64'(gr), 64'(vecs[i].r));
            check($sformatf("vec%0d_dz", i),  64'(gz), 64'(vecs[i].z));
            check($sformatf("vec%0d_lat", i), 64'(lat), vecs[i].z ? 64'd1 : 64'd33);
            check($sformatf("vec%0d_busy", i), 64'(bc), vecs[i].z ? 64'd0 : 64'd32);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // start during RUN is ignored
        @(negedge clk);
        start = 1'b1; A = 32'd100; B = 32'd7;
        lat = 0;
        seen_done = 1'b0;
        while (!seen_done && lat < 60) begin
            @(negedge clk);
            lat++;
            start = (lat == 10);
            if (lat == 10) begin A = 32'd9; B = 32'd3; end
            seen_done = done;
        end
        start = 1'b0;
        check("ignore_lat", 64'(lat), 64'd33);
        check("ignore_q",   64'(Q),   64'd14);
        check("ignore_r",   64'(R),   64'd2);
        @(negedge clk);
        check("ignore_no_restart", 64'(busy), 64'd0);

        // Reset mid-RUN aborts without done
        @(negedge clk);
        start = 1'b1; A = 32'd1000; B = 32'd3;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_q",    64'(Q),    64'd0);
        check("abort_r",    64'(R),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        do_div(32'd1000, 32'd3, gq, gr, gz, lat, bc);
        check("after_abort_q", 64'(gq), 64'd333);
        check("after_abort_r", 64'(gr), 64'd1);

        // Random back-to-back regression, new start issued in each done cycle
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            ra = $urandom;
            qa.push_back(ra);
            qb.push_back(rb);
            exp_q.push_back(model(ra, rb));
        end
        ra = qa.pop_front();
        rb = qb.pop_front();
        start = 1'b1; A = ra; B = rb;
        for (int i = 0; i < 1000; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) start = 1'b0;
            end while (!done && cyc < 60);
            check("rand_spacing", 64'(cyc), 64'd33);
            e = exp_q.pop_front();
            check("rand_qr", {Q, R}, e);
            check("rand_identity",
                  64'((64'(Q) * 64'(rb) + 64'(R) == 64'(ra)) && (R < rb)), 64'd1);
            if (i < 999) begin
                ra = qa.pop_front();
                rb = qb.pop_front();
                start = 1'b1; A = ra; B = rb;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
